rb_write_ctrl: RTL and testbench
================================

Name: rb_write_ctrl

Overview:
- Stream front-end for the row-buffer memory stage of the neighbourhood-image-processing pipeline.
- Accepts a raster pixel stream over a valid/ready handshake and generates the write-port controls (enable, address, row-buffer select, data) for the row buffers.
- Issues the matching read-port address every cycle and tags each packed column read with the row-order information the downstream window stage needs.
- Circular row-buffer management: the newest row overwrites the oldest buffer.

Parameters:
- PIXEL_WIDTH, 8, bits per pixel; matches the row-buffer data width.
- RBS, 4, number of row buffers (window height); must be ≥ 2.
- IMG_WIDTH, 640, pixels per row; must be ≤ row-buffer depth.
- IMG_HEIGHT, 480, rows per frame; must be ≥ RBS.
- COL_W, clog2(IMG_WIDTH), row-buffer address width.
- RB_W, clog2(RBS), row-buffer select width (minimum 1).
- ROW_W, clog2(IMG_HEIGHT+1), row counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame-start pulse; honoured only in IDLE
- s_valid  in  1  input pixel valid
- s_data  in  PIXEL_WIDTH  input pixel
- s_ready  out  1  ready to accept a pixel
- wr_en  out  1  row-buffer write enable
- wr_addr  out  COL_W  write column
- wr_rb  out  RB_W  row buffer being written
- wr_data  out  PIXEL_WIDTH  write pixel
- rd_en  out  1  read enable
- rd_addr  out  COL_W  read column
- win_valid  out  1  packed read data returning this cycle forms a valid window column
- top_rb  out  RB_W  index of the oldest row in the returning column
- live_px  out  PIXEL_WIDTH  current-row pixel aligned with the returning column
- col_idx  out  COL_W  column of the returning data
- frame_done  out  1  one-cycle pulse after the last pixel of the frame

Behaviour:
- Reset (async assert, sync deassert):
  - state = IDLE; all counters = 0; wr_rb = 0.
  - Every output = 0: s_ready, wr_en, rd_en, win_valid, frame_done, top_rb, live_px, col_idx, wr_addr, rd_addr, wr_data.
- States:
  - IDLE → PRIME on start.
  - PRIME → STREAM when rows_done reaches RBS-1.
  - STREAM → DONE after the last pixel of row IMG_HEIGHT-1 is accepted.
  - DONE → IDLE after one cycle, with frame_done = 1 during that cycle.
- s_ready = 1 only in PRIME and STREAM. It is combinational from state, not from s_valid.
- Acceptance = s_valid & s_ready.
- On acceptance, combinationally in the same cycle:
  - wr_en = 1, wr_addr = col, wr_rb = cur_rb, wr_data = s_data.
  - rd_en = 1, rd_addr = col.
- No acceptance → wr_en = 0, rd_en = 0.
- Counters on acceptance:
  - col wraps IMG_WIDTH-1 → 0.
  - On wrap: rows_done += 1 and cur_rb advances modulo RBS (RBS-1 → 0; non-power-of-two RBS supported).
- Read-during-write at the same address returns OLD data in lane cur_rb. Downstream ignores that lane and uses live_px instead.
- Alignment to the 1-cycle row-buffer read latency: the following are registered one cycle after acceptance.
  - win_valid = 1 iff the acceptance happened in STREAM.
  - top_rb = (cur_rb+1) mod RBS, captured at acceptance.
  - live_px = s_data, captured at acceptance.
  - col_idx = col, captured at acceptance.
- Input stall (s_valid low): no writes, counters hold, win_valid = 0 the next cycle.
- start while not in IDLE: ignored.
- The final write of the frame occurs in STREAM. DONE accepts nothing.
- Reset mid-frame: state returns to IDLE and pointers return to 0. Row-buffer contents are not cleared; the next frame re-primes.

Decomposition:
- Shared package/header holds: PIXEL_WIDTH, RBS, IMG_WIDTH, IMG_HEIGHT, derived widths, and the state encoding constants (IDLE, PRIME, STREAM, DONE).
- One natural sub-module: rb_mod_counter (parameterised modulo-N counter with enable and wrap pulse). It is used twice: column counter, and row-buffer pointer chained on the column wrap.
- The row counter and FSM stay in the top.

Test Plan:
All scenarios use RBS=3, IMG_WIDTH=4, IMG_HEIGHT=6.
- Reset/idle: rst_n low mid-clock → all outputs 0 immediately. Assert s_valid with no start → s_ready stays 0, no wr_en.
- Priming: start, then 8 continuous pixels 0..7 → wr_rb sequence 0,0,0,0,1,1,1,1, wr_addr 0,1,2,3,0,1,2,3, win_valid stays 0.
- First window: 9th pixel (value 8) → wr_rb=2, rd_addr=0. Next cycle: win_valid=1, top_rb=0, live_px=8, col_idx=0.
- Wrap: row 3 pixels → wr_rb=0, top_rb=1. Row 5 → wr_rb=2, top_rb=0.
- Stall: drop s_valid for 3 cycles mid-row 4 → wr_en=0, win_valid=0 on the following cycles. On resume, col continues from the held value with no skip or duplicate.
- End/restart: 24th pixel accepted → DONE, frame_done=1 for exactly 1 cycle, s_ready=0, then IDLE. A start during STREAM is ignored. A new start restarts at wr_rb=0 with win_valid=0 for the first 8 pixels.

Source files
------------

// File: rtl/rb_write_ctrl_pkg.sv
// Shared constants, derived widths and state encoding for the row-buffer write front-end.
package rb_write_ctrl_pkg;

    // Address/select width for a range of n values, never narrower than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned PIXEL_WIDTH = 8;
    localparam int unsigned RBS         = 4;
    localparam int unsigned IMG_WIDTH   = 640;
    localparam int unsigned IMG_HEIGHT  = 480;

    localparam int unsigned COL_W = width_of(IMG_WIDTH);
    localparam int unsigned RB_W  = width_of(RBS);
    localparam int unsigned ROW_W = width_of(IMG_HEIGHT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StPrime,
        StStream,
        StDone
    } state_e;

endpackage

// File: rtl/rb_write_ctrl_mod_counter.sv
// Modulo-N counter with synchronous clear, count enable and a same-cycle wrap pulse.
module rb_mod_counter
    import rb_write_ctrl_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = width_of(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign wrap  = en && (count_q == W'(N - 1));
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (wrap) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rb_write_ctrl.sv
// Raster-stream front-end for the row buffers: write-port controls, matching read address,
// and window-column tags aligned to the one-cycle row-buffer read latency.
module rb_write_ctrl
    import rb_write_ctrl_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH = rb_write_ctrl_pkg::PIXEL_WIDTH,
    parameter int unsigned RBS         = rb_write_ctrl_pkg::RBS,
    parameter int unsigned IMG_WIDTH   = rb_write_ctrl_pkg::IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT  = rb_write_ctrl_pkg::IMG_HEIGHT,
    parameter int unsigned COL_W       = width_of(IMG_WIDTH),
    parameter int unsigned RB_W        = width_of(RBS),
    parameter int unsigned ROW_W       = width_of(IMG_HEIGHT + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   s_valid,
    input  logic [PIXEL_WIDTH-1:0] s_data,
    output logic                   s_ready,
    output logic                   wr_en,
    output logic [COL_W-1:0]       wr_addr,
    output logic [RB_W-1:0]        wr_rb,
    output logic [PIXEL_WIDTH-1:0] wr_data,
    output logic                   rd_en,
    output logic [COL_W-1:0]       rd_addr,
    output logic                   win_valid,
    output logic [RB_W-1:0]        top_rb,
    output logic [PIXEL_WIDTH-1:0] live_px,
    output logic [COL_W-1:0]       col_idx,
    output logic                   frame_done
);

    state_e           state_q;
    logic [ROW_W-1:0] rows_done_q;
    logic [COL_W-1:0] col;
    logic [RB_W-1:0]  cur_rb;
    logic [RB_W-1:0]  oldest_rb;
    logic             col_wrap;
    logic             unused_rb_wrap;
    logic             accept;
    logic             start_frame;

    assign s_ready     = (state_q == StPrime) || (state_q == StStream);
    assign accept      = s_valid && s_ready;
    assign start_frame = (state_q == StIdle) && start;

    rb_mod_counter #(
        .N (IMG_WIDTH),
        .W (COL_W)
    ) u_col_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_frame),
        .en    (accept),
        .count (col),
        .wrap  (col_wrap)
    );

    // Newest row always lands in the buffer holding the oldest one.
    rb_mod_counter #(
        .N (RBS),
        .W (RB_W)
    ) u_rb_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_frame),
        .en    (col_wrap),
        .count (cur_rb),
        .wrap  (unused_rb_wrap)
    );

    assign oldest_rb = (cur_rb == RB_W'(RBS - 1)) ? '0 : cur_rb + 1'b1;

    assign wr_en   = accept;
    assign rd_en   = accept;
    assign wr_addr = accept ? col : '0;
    assign rd_addr = accept ? col : '0;
    assign wr_data = accept ? s_data : '0;
    assign wr_rb   = cur_rb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rows_done_q <= '0;
            win_valid   <= 1'b0;
            top_rb      <= '0;
            live_px     <= '0;
            col_idx     <= '0;
            frame_done  <= 1'b0;
        end else begin
            win_valid  <= accept && (state_q == StStream);
            frame_done <= 1'b0;
            if (accept) begin
                top_rb  <= oldest_rb;
                live_px <= s_data;
                col_idx <= col;
            end
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StPrime;
                        rows_done_q <= '0;
                    end
                end
                StPrime: begin
                    // Switch on the wrap itself so the very next pixel is already a window pixel.
                    if (accept && col_wrap) begin
                        rows_done_q <= rows_done_q + 1'b1;
                        if (rows_done_q == ROW_W'(RBS - 2)) begin
                            state_q <= StStream;
                        end
                    end
                end
                StStream: begin
                    if (accept && col_wrap) begin
                        rows_done_q <= rows_done_q + 1'b1;
                        if (rows_done_q == ROW_W'(IMG_HEIGHT - 1)) begin
                            state_q    <= StDone;
                            frame_done <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rb_write_ctrl.sv
// Bench for rb_write_ctrl with RBS=3, IMG_WIDTH=4, IMG_HEIGHT=6: pixel-count model plus
// directed literal expectations.
module tb_rb_write_ctrl;

    localparam int IW  = 4;
    localparam int IH  = 6;
    localparam int NRB = 3;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [1:0] wr_rb;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [1:0] rd_addr;
    logic       win_valid;
    logic [1:0] top_rb;
    logic [7:0] live_px;
    logic [1:0] col_idx;
    logic       frame_done;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Model state: whether a frame is open and how many pixels of it were accepted.
    bit         m_active;
    int         m_k;
    bit         m_done;
    bit         m_wv;
    int         m_top;
    logic [7:0] m_live;
    int         m_col;

    int prime_rb   [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    int prime_addr [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    rb_write_ctrl #(
        .PIXEL_WIDTH (8),
        .RBS         (NRB),
        .IMG_WIDTH   (IW),
        .IMG_HEIGHT  (IH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_rb      (wr_rb),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .win_valid  (win_valid),
        .top_rb     (top_rb),
        .live_px    (live_px),
        .col_idx    (col_idx),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_done   <= 1'b0;
            m_wv     <= 1'b0;
            m_top    <= 0;
            m_live   <= '0;
            m_col    <= 0;
        end else begin
            m_wv   <= s_valid && m_active && (m_k / IW >= NRB - 1);
            m_done <= s_valid && m_active && (m_k == IW * IH - 1);
            if (s_valid && m_active) begin
                m_top  <= (m_k / IW + 1) % NRB;
                m_live <= s_data;
                m_col  <= m_k % IW;
                m_k    <= m_k + 1;
                if (m_k == IW * IH - 1) m_active <= 1'b0;
            end else if (!m_active && !m_done && start) begin
                m_active <= 1'b1;
                m_k      <= 0;
            end
        end
    end

    always @(negedge clk) begin
        bit acc;
        if (rst_n && chk_en) begin
            acc = s_valid && m_active;
            chk("m_s_ready", 32'(s_ready), 32'(m_active));
            chk("m_wr_en", 32'(wr_en), 32'(acc));
            chk("m_rd_en", 32'(rd_en), 32'(acc));
            if (acc) begin
                chk("m_wr_addr", 32'(wr_addr), m_k % IW);
                chk("m_rd_addr", 32'(rd_addr), m_k % IW);
                chk("m_wr_rb", 32'(wr_rb), (m_k / IW) % NRB);
                chk("m_wr_data", 32'(wr_data), 32'(s_data));
            end
            chk("m_win_valid", 32'(win_valid), 32'(m_wv));
            if (m_wv) begin
                chk("m_top_rb", 32'(top_rb), m_top);
                chk("m_live_px", 32'(live_px), 32'(m_live));
                chk("m_col_idx", 32'(col_idx), m_col);
            end
            chk("m_frame_done", 32'(frame_done), 32'(m_done));
        end
    end

    task automatic drive(input bit v, input logic [7:0] d);
        s_valid = v;
        s_data  = d;
        #3;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 0);
        chk({tag, "_wr_en"}, 32'(wr_en), 0);
        chk({tag, "_rd_en"}, 32'(rd_en), 0);
        chk({tag, "_win_valid"}, 32'(win_valid), 0);
        chk({tag, "_frame_done"}, 32'(frame_done), 0);
        chk({tag, "_top_rb"}, 32'(top_rb), 0);
        chk({tag, "_live_px"}, 32'(live_px), 0);
        chk({tag, "_col_idx"}, 32'(col_idx), 0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
        chk({tag, "_wr_data"}, 32'(wr_data), 0);
        chk({tag, "_wr_rb"}, 32'(wr_rb), 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst");
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Valid data without a start must be refused.
        drive(1'b1, 8'hAA);
        chk("idle_s_ready", 32'(s_ready), 0);
        chk("idle_wr_en", 32'(wr_en), 0);
        step();
        step();
        drive(1'b0, 8'h00);

        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(i));
            chk("prime_wr_rb", 32'(wr_rb), prime_rb[i]);
            chk("prime_wr_addr", 32'(wr_addr), prime_addr[i]);
            step();
            chk("prime_win_valid", 32'(win_valid), 0);
        end

        drive(1'b1, 8'd8);
        chk("first_wr_rb", 32'(wr_rb), 2);
        chk("first_rd_addr", 32'(rd_addr), 0);
        step();
        chk("first_win_valid", 32'(win_valid), 1);
        chk("first_top_rb", 32'(top_rb), 0);
        chk("first_live_px", 32'(live_px), 8);
        chk("first_col_idx", 32'(col_idx), 0);
        for (int i = 9; i < 12; i++) begin
            drive(1'b1, 8'(i));
            step();
        end

        drive(1'b1, 8'd12);
        chk("row3_wr_rb", 32'(wr_rb), 0);
        step();
        chk("row3_top_rb", 32'(top_rb), 1);
        start = 1'b1;
        drive(1'b1, 8'd13);
        step();
        start = 1'b0;
        drive(1'b1, 8'd14);
        step();
        drive(1'b1, 8'd15);
        step();

        drive(1'b1, 8'd16);
        step();
        drive(1'b1, 8'd17);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'hFF);
            chk("stall_wr_en", 32'(wr_en), 0);
            step();
            chk("stall_win_valid", 32'(win_valid), 0);
        end
        drive(1'b1, 8'd18);
        chk("resume_wr_addr", 32'(wr_addr), 2);
        step();
        chk("resume_col_idx", 32'(col_idx), 2);
        chk("resume_live_px", 32'(live_px), 18);
        drive(1'b1, 8'd19);
        step();

        drive(1'b1, 8'd20);
        chk("row5_wr_rb", 32'(wr_rb), 2);
        step();
        chk("row5_top_rb", 32'(top_rb), 0);
        for (int i = 21; i < 23; i++) begin
            drive(1'b1, 8'(i));
            step();
        end
        drive(1'b1, 8'd23);
        chk("last_wr_addr", 32'(wr_addr), 3);
        step();
        chk("done_frame_done", 32'(frame_done), 1);
        chk("done_s_ready", 32'(s_ready), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("idle_frame_done", 32'(frame_done), 0);
        chk("idle_after_s_ready", 32'(s_ready), 0);
        drive(1'b0, 8'h00);
        step();

        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'(100 + i));
            if (i < 8) chk("re_wr_rb", 32'(wr_rb), prime_rb[i]);
            step();
            chk("re_win_valid", 32'(win_valid), (i >= 8) ? 1 : 0);
        end

        // Asynchronous reset in the middle of a clock phase and of a frame.
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        step();
        rst_n = 1'b1;
        drive(1'b0, 8'h00);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 8'(200 + i));
            if (i == 0) chk("post_rst_wr_rb", 32'(wr_rb), 0);
            step();
        end
        chk("post_rst_win_valid", 32'(win_valid), 1);
        chk("post_rst_live_px", 32'(live_px), 208);
        drive(1'b0, 8'h00);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
